// File: rtl/nios_system_pkg.sv
// Shared definitions for the Nios II system slave ports: register addresses,
// edge-type encodings and a per-bit edge classification helper.
package nios_system_pkg;

  // Register map of the input port slave
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Which transition of the stable level sets an EDGE_CAPTURE bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when the transition prev -> cur matches the selected edge type
  function automatic logic edge_bit(input int etype, input logic cur, input logic prev);
    case (etype)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/nios_system_debounce.sv
// Single-bit debouncer: the output follows the synchronised input only after
// the input has disagreed with it for DB_CYCLES consecutive clocks.
module nios_system_debounce #(
  parameter int   DB_CYCLES  = 500000,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          stable_reg;

  // Count consecutive mismatching cycles; accept the new level on the last one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      stable_reg <= IDLE_LEVEL;
    end else if (din == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      stable_reg <= din;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign dout = stable_reg;

endmodule

// File: rtl/nios_system_key_in.sv
// Avalon-MM input port: 2-FF synchroniser, optional per-bit debounce,
// DATA / IRQ_MASK / EDGE_CAPTURE registers and a level interrupt.
// Debounce is built only when NIOS_SYSTEM_KEY_IN_DEBOUNCE_EN is defined.
module nios_system_key_in
  import nios_system_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   EDGE_TYPE  = 1,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   DB_CYCLES  = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_PATTERN = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;
  logic [31:0]      unused_wdata;

  // Upper write-data bits have no backing register
  assign unused_wdata = writedata;

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= IDLE_PATTERN;
      sync2_reg <= IDLE_PATTERN;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef NIOS_SYSTEM_KEY_IN_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    nios_system_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync2_reg[gi]),
      .dout    (stable[gi])
    );
  end
`else
  localparam int unused_db_cycles = DB_CYCLES;
  assign stable = sync2_reg;
`endif

  // Previous stable level, the reference for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_reg <= IDLE_PATTERN;
    end else begin
      stable_d_reg <= stable;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign edge_hit[gi] = edge_bit(EDGE_TYPE, stable[gi], stable_d_reg[gi]);
  end

  assign wr_en = chipselect && !write_n;

  // Write-1-to-clear mask for EDGE_CAPTURE
  always_comb begin
    w1c = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      w1c = writedata[WIDTH-1:0];
    end
  end

  // Mask register and edge capture; a new edge overrides a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
      edge_reg <= '0;
    end else begin
      if (wr_en && (address == ADDR_MASK)) begin
        mask_reg <= writedata[WIDTH-1:0];
      end
      edge_reg <= (edge_reg & ~w1c) | edge_hit;
    end
  end

  // Zero-latency read mux, zero-extended to the bus width
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = stable;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_reg;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_reg;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_nios_system_key_in.sv
// Self-checking bench for nios_system_key_in (WIDTH=4, falling edges,
// idle-high pins, DB_CYCLES=4). Follows NIOS_SYSTEM_KEY_IN_DEBOUNCE_EN.
module tb_nios_system_key_in;

  localparam int WIDTH = 4;
  localparam int EDGE_TYPE = 1;
  localparam int DB = 4;
`ifdef NIOS_SYSTEM_KEY_IN_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
  localparam int LAT = 3 + DB;
`else
  localparam bit DB_ON = 1'b0;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  nios_system_key_in #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .IDLE_LEVEL (1'b1),
    .DB_CYCLES  (DB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] m_s1, m_s2, m_st, m_std, m_mask, m_edge;
  logic [3:0] m_hist [0:DB-1];
  logic [3:0] m_data;

  assign m_data = DB_ON ? m_st : m_s2;

  function automatic logic [3:0] edges_of(input logic [3:0] cur, input logic [3:0] prev);
    case (EDGE_TYPE)
      0: return cur & ~prev;
      1: return ~cur & prev;
      default: return cur ^ prev;
    endcase
  endfunction

  // A bit settles once the last DB synchronised samples all differ from it
  function automatic logic [3:0] settle(input logic [3:0] cur);
    logic [3:0] nxt;
    nxt = cur;
    for (int i = 0; i < 4; i++) begin
      bit all_diff;
      all_diff = (m_s2[i] != cur[i]);
      for (int k = 0; k < DB - 1; k++)
        if (m_hist[k][i] == cur[i]) all_diff = 1'b0;
      if (all_diff) nxt[i] = ~cur[i];
    end
    return nxt;
  endfunction

  function automatic logic [3:0] w1c_now();
    if (chipselect && !write_n && address == 2'd3) return writedata[3:0];
    return 4'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= 4'hF; m_s2 <= 4'hF; m_st <= 4'hF; m_std <= 4'hF;
      m_mask <= 4'h0; m_edge <= 4'h0;
      for (int k = 0; k < DB; k++) m_hist[k] <= 4'hF;
    end else begin
      m_s1 <= in_port;
      m_s2 <= m_s1;
      m_std <= m_data;
      m_edge <= (m_edge & ~w1c_now()) | edges_of(m_data, m_std);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
      m_st <= settle(m_st);
      m_hist[0] <= m_s2;
      for (int k = 1; k < DB; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {28'h0, m_data};
      2'd2: return {28'h0, m_mask};
      2'd3: return {28'h0, m_edge};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_readdata", readdata, model_rd(address));
      check("cmp_irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] v;

  initial begin
    step(3);
    cmp_en = 1'b1;
    reset_n = 1'b1;

    // Reset release with idle pins
    rd(2'd0, v); check("reset_data", v, 32'h0000000F);
    for (int i = 0; i < 20; i++) begin
      rd(2'd3, v); check("reset_edge", v, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      step(1);
    end

    // Falling edge on bit0, masked in
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    step(LAT - 1);
    rd(2'd3, v); check("edge0_early", v, 32'h0);
    step(1);
    rd(2'd3, v); check("edge0_set", v, 32'h1);
    check("edge0_irq", {31'h0, irq}, 32'h1);
    in_port = 4'hF;
    step(LAT + 2);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h0);

    // Short glitch on bit2: rejected only with debounce
    in_port = 4'hB; step(3); in_port = 4'hF;
    step(LAT + 4);
    rd(2'd0, v); check("glitch_data", v, 32'hF);
    rd(2'd3, v); check("glitch_edge", v, DB_ON ? 32'h0 : 32'h4);
    wr(2'd3, 32'hF);
    in_port = 4'hB; step(6); in_port = 4'hF;
    step(LAT + 4);
    rd(2'd3, v); check("pulse_edge", v, 32'h4);
    wr(2'd3, 32'hF);

    // W1C and mask interplay
    in_port = 4'hA; step(LAT + 1); in_port = 4'hF; step(LAT + 2);
    rd(2'd3, v); check("edge5", v, 32'h5);
    wr(2'd2, 32'h4);
    wr(2'd3, 32'h4);
    rd(2'd3, v); check("w1c_edge", v, 32'h1);
    check("w1c_irq", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    check("mask_irq", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h0);

    // Edge on bit1 coincides with a W1C of bit1: edge wins
    in_port = 4'hD;
    step(LAT - 1);
    wr(2'd3, 32'h2);
    rd(2'd3, v); check("edge_vs_w1c", v, 32'h2);
    in_port = 4'hF; step(LAT + 2);
    wr(2'd3, 32'hF);

    // Async reset mid-debounce with all edges pending
    wr(2'd2, 32'hF);
    in_port = 4'h0; step(LAT + 1);
    rd(2'd3, v); check("pre_reset_edge", v, 32'hF);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    in_port = 4'hF; step(2);
    reset_n = 1'b0;
    #1;
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd(2'd0, v); check("rst_data", v, 32'hF);
    rd(2'd2, v); check("rst_mask", v, 32'h0);
    rd(2'd3, v); check("rst_edge", v, 32'h0);
    step(3);
    reset_n = 1'b1;
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hFFFFFFFF);
    rd(2'd1, v); check("rsvd_read", v, 32'h0);
    rd(2'd0, v); check("data_ro", v, 32'hF);
    step(LAT + 2);
    rd(2'd3, v); check("no_edge_after_rst", v, 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
      r = $urandom_range(0, 5);
      if (r == 0) wr(2'd2, $urandom);
      else if (r == 1) wr(2'd3, $urandom);
      else begin
        address = 2'($urandom);
        step(1);
      end
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
